inst_encoder: RTL and testbench

Streaming RV32I instruction encoder that packs decoded fields (format, opcode, funct3/funct7, register indices, full-width immediate) into a 32-bit instruction word. It is the inverse of the core's immediate generator and uses the same imm_sel_t format encoding. It serves the program-loader/self-test sequencer that writes instruction memory, and the bench's instruction builder. The datapath is a 2-stage valid/ready pipeline with a handshake counter and optional immediate legality checking.

---
 rtl/inst_encoder_if.sv | 30 +++
 rtl/inst_encoder.sv | 188 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Field/word handshake bundle for inst_encoder.
// slave is the encoder side; master is the producer/consumer side.
interface inst_encoder_if;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  fmt_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic        err_o;

    modport slave (
        input  valid_i, fmt_i, opcode_i, funct3_i, funct7_i,
        input  rd_i, rs1_i, rs2_i, imm_i, ready_i,
        output ready_o, valid_o, inst_o, err_o
    );

    modport master (
        output valid_i, fmt_i, opcode_i, funct3_i, funct7_i,
        output rd_i, rs1_i, rs2_i, imm_i, ready_i,
        input  ready_o, valid_o, inst_o, err_o
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: 2-stage valid/ready pipeline, fields in, word out.
// Optional immediate legality check built only when IMM_CHECK_EN is defined.
module inst_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    inst_encoder_if.slave    bus,
    input  logic             clr_i,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] count_o
);
    typedef enum logic [2:0] {
        IMM_I_TYPE = 3'd0,
        IMM_S_TYPE = 3'd1,
        IMM_B_TYPE = 3'd2,
        IMM_U_TYPE = 3'd3,
        IMM_J_TYPE = 3'd4
    } imm_sel_t;

    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_fmt_q;
    logic [6:0]  s1_op_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [31:0] s1_imm_q;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic adv;
    logic acc;
    logic out_hs;
    logic [31:0] word;

    // Stage 2 frees up whenever it is empty or being drained.
    assign adv    = !s2_valid_q || bus.ready_i;
    assign bus.ready_o = !s1_valid_q || adv;
    assign acc    = bus.valid_i && bus.ready_o;
    assign out_hs = s2_valid_q && bus.ready_i;

    assign s1_valid_d = acc || (s1_valid_q && !adv);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= '0;
            s1_op_q    <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_imm_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (acc) begin
                s1_fmt_q <= bus.fmt_i;
                s1_op_q  <= bus.opcode_i;
                s1_f3_q  <= bus.funct3_i;
                s1_f7_q  <= bus.funct7_i;
                s1_rd_q  <= bus.rd_i;
                s1_rs1_q <= bus.rs1_i;
                s1_rs2_q <= bus.rs2_i;
                s1_imm_q <= bus.imm_i;
            end
        end
    end

    always_comb begin
        word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        case (imm_sel_t'(s1_fmt_q))
            IMM_I_TYPE: word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q,
                                s1_rd_q, s1_op_q};
            IMM_S_TYPE: word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                                s1_f3_q, s1_imm_q[4:0], s1_op_q};
            IMM_B_TYPE: word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q,
                                s1_rs1_q, s1_f3_q, s1_imm_q[4:1],
                                s1_imm_q[11], s1_op_q};
            IMM_U_TYPE: word = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
            IMM_J_TYPE: word = {s1_imm_q[20], s1_imm_q[10:1],
                                s1_imm_q[11], s1_imm_q[19:12],
                                s1_rd_q, s1_op_q};
            default: ;
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d = word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.valid_o = s2_valid_q;
    assign bus.inst_o  = s2_inst_q;
    assign count_o     = cnt_q;

`ifdef IMM_CHECK_EN
    logic err_q, err_d;
    logic sticky_q, sticky_d;
    logic chk;
    logic sx12, sx13, sx21;

    // Upper bits all equal means the value fits the signed field.
    assign sx12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    assign sx13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
    assign sx21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);

    always_comb begin
        chk = 1'b0;
        case (imm_sel_t'(s1_fmt_q))
            IMM_I_TYPE: chk = !sx12;
            IMM_S_TYPE: chk = !sx12;
            IMM_B_TYPE: chk = !sx13 || s1_imm_q[0];
            IMM_U_TYPE: chk = |s1_imm_q[11:0];
            IMM_J_TYPE: chk = !sx21 || s1_imm_q[0];
            default:    chk = 1'b0;
        endcase
    end

    always_comb begin
        err_d    = err_q;
        sticky_d = sticky_q;
        if (adv && s1_valid_q) begin
            err_d = chk;
        end else if (adv) begin
            err_d = 1'b0;
        end
        if (clr_i) begin
            sticky_d = 1'b0;
        end else if (out_hs && err_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.err_o    = err_q;
    assign err_sticky_o = sticky_q;
`else
    assign bus.err_o    = 1'b0;
    assign err_sticky_o = 1'b0;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder with an arithmetic model.
// Counter checked at CNT_W=4 so wrap is reachable.
module tb_inst_encoder;
    localparam int CW = 4;
    localparam logic [2:0] F_I = 3'd0;
    localparam logic [2:0] F_S = 3'd1;
    localparam logic [2:0] F_B = 3'd2;
    localparam logic [2:0] F_U = 3'd3;
    localparam logic [2:0] F_J = 3'd4;
`ifdef IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic sticky;
    logic [CW-1:0] count;

    inst_encoder_if bus();

    inst_encoder #(.CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus.slave),
        .clr_i        (clr),
        .err_sticky_o (sticky),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt_m = 0;
    bit sticky_m = 1'b0;
    int n_out = 0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int acc_t[$];
    int got_t[$];

    function automatic longint fld(logic [31:0] v, int hi, int lo);
        return (longint'(v) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Reference: builds the word by shifting and adding each field.
    function automatic logic [32:0] model(
        logic [2:0] f, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
        logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
        longint w;
        int s;
        bit e;
        s = $signed(imm);
        e = 1'b0;
        w = longint'(op);
        case (f)
            F_I: begin
                w += (longint'(rd) << 7) + (longint'(f3) << 12);
                w += (longint'(rs1) << 15) + (fld(imm, 11, 0) << 20);
                e = (s < -2048) || (s > 2047);
            end
            F_S: begin
                w += (fld(imm, 4, 0) << 7) + (longint'(f3) << 12);
                w += (longint'(rs1) << 15) + (longint'(rs2) << 20);
                w += fld(imm, 11, 5) << 25;
                e = (s < -2048) || (s > 2047);
            end
            F_B: begin
                w += (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8);
                w += (longint'(f3) << 12) + (longint'(rs1) << 15);
                w += (longint'(rs2) << 20) + (fld(imm, 10, 5) << 25);
                w += fld(imm, 12, 12) << 31;
                e = (s < -4096) || (s > 4095) || (s % 2 != 0);
            end
            F_U: begin
                w += (longint'(rd) << 7) + (fld(imm, 31, 12) << 12);
                e = (fld(imm, 11, 0) != 0);
            end
            F_J: begin
                w += (longint'(rd) << 7) + (fld(imm, 19, 12) << 12);
                w += (fld(imm, 11, 11) << 20) + (fld(imm, 10, 1) << 21);
                w += fld(imm, 20, 20) << 31;
                e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            end
            default: begin
                w += (longint'(rd) << 7) + (longint'(f3) << 12);
                w += (longint'(rs1) << 15) + (longint'(rs2) << 20);
                w += longint'(f7) << 25;
            end
        endcase
        return {e && CHK, w[31:0]};
    endfunction

    task automatic reset_model();
        exp_q.delete();
        got_q.delete();
        acc_t.delete();
        got_t.delete();
        n_out = 0;
    endtask

    task automatic set_fields(logic [2:0] f, logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [31:0] imm);
        bus.fmt_i = f;
        bus.opcode_i = op;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        bus.rd_i = rd;
        bus.rs1_i = rs1;
        bus.rs2_i = rs2;
        bus.imm_i = imm;
    endtask

    task automatic rand_fields();
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: imm = $urandom & 32'hFFFF_F000;
            2: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
            default: imm = $urandom;
        endcase
        set_fields(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom),
                   7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), imm);
    endtask

    // Samples both handshakes mid-cycle, then advances one edge.
    task automatic tick(output bit acc);
        logic [32:0] e;
        acc = 1'b0;
        @(negedge clk);
        if (rst_n) begin
            if (bus.valid_i && bus.ready_o) begin
                acc = 1'b1;
                exp_q.push_back(model(bus.fmt_i, bus.opcode_i, bus.funct3_i,
                                      bus.funct7_i, bus.rd_i, bus.rs1_i,
                                      bus.rs2_i, bus.imm_i));
                acc_t.push_back(cyc);
            end
            if (bus.valid_o && bus.ready_i) begin
                got_q.push_back({bus.err_o, bus.inst_o});
                got_t.push_back(cyc);
            end
            if (clr) begin
                cnt_m = 0;
                sticky_m = 1'b0;
            end else if (bus.valid_o && bus.ready_i) begin
                cnt_m++;
                e = (n_out < exp_q.size()) ? exp_q[n_out] : 33'd0;
                if (e[32]) sticky_m = 1'b1;
            end
            if (bus.valid_o && bus.ready_i) n_out++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int budget);
        bit a;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= exp_q.size() && !bus.valid_o) break;
            tick(a);
        end
    endtask

    task automatic do_clr();
        bit a;
        clr = 1'b1;
        tick(a);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.inst_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b inst=%h want 0/0",
                     bus.valid_o, bus.inst_o);
        end
        checks++;
        if (bus.err_o !== 1'b0 || sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err=%b sticky=%b want 0/0",
                     bus.err_o, sticky);
        end
        checks++;
        if (count !== '0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt: count=%0d ready=%b want 0/1",
                     count, bus.ready_o);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] want [5];
        bit a;
        want[0] = 32'hFFF10093;
        want[1] = 32'h00512423;
        want[2] = 32'hFE000EE3;
        want[3] = 32'h001000EF;
        want[4] = 32'h123451B7;
        reset_model();
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_fields(F_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0,
                              32'hFFFFFFFF);
                1: set_fields(F_S, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd8);
                2: set_fields(F_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                              -32'sd4);
                3: set_fields(F_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                              32'h800);
                default: set_fields(F_U, 7'h37, 3'd0, 7'd0, 5'd3, 5'd0,
                                    5'd0, 32'h12345000);
            endcase
            tick(a);
            checks++;
            if (!a) begin
                errors++;
                $display("FAIL vec_accept[%0d]: accepted=%b want 1", i, a);
            end
        end
        drain(10);
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL vec_count: got %0d words want 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== {1'b0, want[i]}) begin
                    errors++;
                    $display("FAIL vec_word[%0d]: got %h want %h",
                             i, got_q[i], {1'b0, want[i]});
                end
                checks++;
                if (got_t[i] != acc_t[0] + 2 + i) begin
                    errors++;
                    $display("FAIL vec_latency[%0d]: out cycle %0d want %0d",
                             i, got_t[i], acc_t[0] + 2 + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit a;
        logic [31:0] hold;
        do_clr();
        reset_model();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rand_fields();
            tick(a);
            checks++;
            if (!a) begin
                errors++;
                $display("FAIL bp_accept[%0d]: accepted=%b want 1", k, a);
            end
        end
        rand_fields();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready: ready_o=%b want 0", bus.ready_o);
        end
        hold = bus.inst_o;
        for (int k = 0; k < 3; k++) begin
            tick(a);
            checks++;
            if (a || bus.valid_o !== 1'b1 || bus.inst_o !== hold) begin
                errors++;
                $display("FAIL bp_hold[%0d]: acc=%b valid=%b inst=%h want 0/1/%h",
                         k, a, bus.valid_o, bus.inst_o, hold);
            end
        end
        bus.ready_i = 1'b1;
        for (int k = 0; k < 4 && exp_q.size() < 3; k++) tick(a);
        drain(10);
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL bp_drain: got %0d exp %0d want 3",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_word[%0d]: got %h want %h",
                             i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL bp_count: count=%0d want 3", count);
        end
    endtask

    task automatic test_imm_check();
        bit a;
        do_clr();
        reset_model();
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        set_fields(F_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
        tick(a);
        drain(6);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL chk_i_out: got %0d words want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0][32] !== CHK || got_q[0][31:20] !== 12'h800) begin
                errors++;
                $display("FAIL chk_i_err: err=%b imm=%h want %b/800",
                         got_q[0][32], got_q[0][31:20], CHK);
            end
        end
        checks++;
        if (sticky !== CHK) begin
            errors++;
            $display("FAIL chk_sticky_set: sticky=%b want %b", sticky, CHK);
        end
        bus.valid_i = 1'b1;
        set_fields(F_B, 7'h63, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd6);
        tick(a);
        drain(6);
        checks++;
        if (got_q.size() != 2 || got_q[1] !== exp_q[1] || got_q[1][32]) begin
            errors++;
            $display("FAIL chk_b6: got %h want %h no error",
                     got_q.size() > 1 ? got_q[1] : 33'd0, exp_q[1]);
        end
        do_clr();
        checks++;
        if (sticky !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL chk_clr: sticky=%b count=%0d want 0/0",
                     sticky, count);
        end
    endtask

    task automatic test_random();
        bit a;
        int items = 0;
        do_clr();
        reset_model();
        bus.valid_i = 1'b0;
        rand_fields();
        for (int c = 0; c < 2000 && items < 300; c++) begin
            bus.valid_i = ($urandom_range(0, 3) != 0);
            bus.ready_i = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 40) == 0);
            tick(a);
            clr = 1'b0;
            if (a) begin
                items++;
                rand_fields();
            end
        end
        drain(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_size: got %0d words want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_word[%0d]: got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (count !== CW'(cnt_m) || sticky !== sticky_m) begin
            errors++;
            $display("FAIL rnd_status: count=%0d sticky=%b want %0d/%b",
                     count, sticky, CW'(cnt_m), sticky_m);
        end
    endtask

    task automatic test_reset_midflight();
        bit a;
        reset_model();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rand_fields();
            tick(a);
        end
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: valid_o=%b want 1", bus.valid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || count !== '0 || sticky !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: valid=%b count=%0d sticky=%b want 0/0/0",
                     bus.valid_o, count, sticky);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_m = 0;
        sticky_m = 1'b0;
        reset_model();
        bus.ready_i = 1'b1;
        for (int k = 0; k < 5; k++) tick(a);
        checks++;
        if (got_q.size() != 0 || count !== '0) begin
            errors++;
            $display("FAIL mid_stale: words=%0d count=%0d want 0/0",
                     got_q.size(), count);
        end
    endtask

    task automatic test_wrap();
        bit a;
        do_clr();
        reset_model();
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() < 17; c++) begin
            rand_fields();
            tick(a);
        end
        drain(10);
        checks++;
        if (got_q.size() != 17 || count !== 4'd1) begin
            errors++;
            $display("FAIL wrap: words=%0d count=%0d want 17/1",
                     got_q.size(), count);
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        @(posedge clk);
        #1;
        test_vectors();
        test_backpressure();
        test_imm_check();
        test_random();
        test_reset_midflight();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
